// File: rtl/flash_pkg.sv
// Shared definitions for the flash prefetch line buffer.
package flash_pkg;

  localparam int unsigned LineWords = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StPass,
    StAck
  } flash_state_e;

endpackage

// File: rtl/flash_prefetch.sv
// Single-line read prefetch buffer between a 32-bit Wishbone CPU port and a slow flash controller.
// Full-word reads are served from a 4-word line; everything else is passed straight through.
module flash_prefetch
  import flash_pkg::*;
#(
  parameter int unsigned adr_width  = 22,
  parameter int unsigned line_words = LineWords
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] s_wb_adr_i,
  input  logic [31:0] s_wb_dat_i,
  output logic [31:0] s_wb_dat_o,
  input  logic [3:0]  s_wb_sel_i,
  input  logic        s_wb_stb_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_we_i,
  output logic        s_wb_ack_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_we_o,
  input  logic        m_wb_ack_i,
  input  logic        invalidate
);

  localparam int unsigned TagW = adr_width - 3;

  flash_state_e state_q, state_d;

  logic [31:0]     line_q [line_words];
  logic [TagW-1:0] tag_q;
  logic            valid_q;
  logic [1:0]      word_q;
  logic [1:0]      req_word_q;
  logic            live_q;
  logic            inv_pend_q;
  logic [31:0]     s_dat_q;
  logic [31:0]     m_adr_q;
  logic [31:0]     m_dat_q;
  logic [3:0]      m_sel_q;
  logic            m_cyc_q;
  logic            m_stb_q;
  logic            m_we_q;

  logic req, cacheable, tag_hit, hit, resp_live;

  assign req       = s_wb_cyc_i & s_wb_stb_i;
  assign cacheable = req & ~s_wb_we_i & (s_wb_sel_i == 4'b1111);
  assign tag_hit   = (s_wb_adr_i[adr_width:4] == tag_q);
  assign hit       = cacheable & valid_q & tag_hit;
  // The CPU is still waiting only if it has held cyc for the whole downstream access.
  assign resp_live = live_q & s_wb_cyc_i;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = hit ? StAck : (cacheable ? StFill : StPass);
        end
      end
      StFill: begin
        if (m_wb_ack_i && (word_q == 2'd3)) begin
          state_d = resp_live ? StAck : StIdle;
        end
      end
      StPass: begin
        if (m_wb_ack_i) begin
          state_d = resp_live ? StAck : StIdle;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_wb_ack_o = (state_q == StAck);
    s_wb_dat_o = s_dat_q;
    m_wb_adr_o = m_adr_q;
    m_wb_dat_o = m_dat_q;
    m_wb_sel_o = m_sel_q;
    m_wb_cyc_o = m_cyc_q;
    m_wb_stb_o = m_stb_q;
    m_wb_we_o  = m_we_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      valid_q    <= 1'b0;
      tag_q      <= '0;
      word_q     <= 2'd0;
      req_word_q <= 2'd0;
      live_q     <= 1'b0;
      inv_pend_q <= 1'b0;
      s_dat_q    <= '0;
      m_adr_q    <= '0;
      m_dat_q    <= '0;
      m_sel_q    <= '0;
      m_cyc_q    <= 1'b0;
      m_stb_q    <= 1'b0;
      m_we_q     <= 1'b0;
    end else begin
      if (invalidate) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (req) begin
            live_q <= 1'b1;
            if (hit) begin
              s_dat_q <= line_q[s_wb_adr_i[3:2]];
            end else if (cacheable) begin
              m_adr_q    <= {s_wb_adr_i[31:4], 4'b0000};
              m_sel_q    <= 4'b1111;
              m_we_q     <= 1'b0;
              m_cyc_q    <= 1'b1;
              m_stb_q    <= 1'b1;
              word_q     <= 2'd0;
              req_word_q <= s_wb_adr_i[3:2];
              valid_q    <= 1'b0;
              inv_pend_q <= invalidate;
            end else begin
              m_adr_q <= s_wb_adr_i;
              m_dat_q <= s_wb_dat_i;
              m_sel_q <= s_wb_sel_i;
              m_we_q  <= s_wb_we_i;
              m_cyc_q <= 1'b1;
              m_stb_q <= 1'b1;
              if (s_wb_we_i && tag_hit) begin
                valid_q <= 1'b0;
              end
            end
          end
        end
        StFill: begin
          if (invalidate) begin
            inv_pend_q <= 1'b1;
          end
          if (!s_wb_cyc_i) begin
            live_q <= 1'b0;
          end
          if (m_wb_ack_i) begin
            if (word_q == req_word_q) begin
              s_dat_q <= m_wb_dat_i;
            end
            word_q        <= word_q + 2'd1;
            m_adr_q[3:2]  <= word_q + 2'd1;
            if (word_q == 2'd3) begin
              tag_q   <= m_adr_q[adr_width:4];
              valid_q <= ~(inv_pend_q | invalidate);
              m_cyc_q <= 1'b0;
              m_stb_q <= 1'b0;
            end
          end
        end
        StPass: begin
          if (!s_wb_cyc_i) begin
            live_q <= 1'b0;
          end
          if (m_wb_ack_i) begin
            s_dat_q <= m_wb_dat_i;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset; valid_q guards it.
  always_ff @(posedge sys_clk) begin
    if ((state_q == StFill) && m_wb_ack_i) begin
      line_q[word_q] <= m_wb_dat_i;
    end
  end

endmodule

// File: tb/tb_flash_prefetch.sv
// Self-checking bench for flash_prefetch: directed scenarios plus randomized traffic vs a line model.
module tb_flash_prefetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0;
  logic [31:0] s_wb_dat_o;
  logic [3:0]  s_wb_sel_i = '0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_cyc_i = 1'b0;
  logic        s_wb_we_i = 1'b0;
  logic        s_wb_ack_o;
  logic [31:0] m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic [31:0] m_wb_dat_i = '0;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_stb_o;
  logic        m_wb_cyc_o;
  logic        m_wb_we_o;
  logic        m_wb_ack_i = 1'b0;
  logic        invalidate = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  txn_t mon_q[$];
  int   ds_cnt = 0;

  // Reference line state
  logic        mv = 1'b0;
  logic [18:0] mtag = '0;
  logic [31:0] mline [4];

  always #5 sys_clk = ~sys_clk;

  flash_prefetch dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .s_wb_adr_i (s_wb_adr_i),
    .s_wb_dat_i (s_wb_dat_i),
    .s_wb_dat_o (s_wb_dat_o),
    .s_wb_sel_i (s_wb_sel_i),
    .s_wb_stb_i (s_wb_stb_i),
    .s_wb_cyc_i (s_wb_cyc_i),
    .s_wb_we_i  (s_wb_we_i),
    .s_wb_ack_o (s_wb_ack_o),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_sel_o (m_wb_sel_o),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_cyc_o (m_wb_cyc_o),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_ack_i (m_wb_ack_i),
    .invalidate (invalidate)
  );

  // Downstream flash controller: ack on the third cycle of stb, read data = byte address.
  always @(negedge sys_clk) begin
    if (sys_rst || !(m_wb_cyc_o && m_wb_stb_o)) begin
      m_wb_ack_i = 1'b0;
      ds_cnt = 0;
    end else if (m_wb_ack_i) begin
      m_wb_ack_i = 1'b0;
      ds_cnt = 1;
    end else begin
      ds_cnt++;
      if (ds_cnt == 3) begin
        m_wb_ack_i = 1'b1;
        m_wb_dat_i = m_wb_adr_o;
        mon_q.push_back('{adr: m_wb_adr_o, sel: m_wb_sel_o, we: m_wb_we_o, dat: m_wb_dat_o});
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_req(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                        input logic [31:0] dat, input logic inv,
                        output logic [31:0] rdat, output int lat, output logic got);
    mon_q.delete();
    rdat = '0;
    got  = 1'b0;
    lat  = 0;
    @(negedge sys_clk);
    s_wb_adr_i = adr;
    s_wb_sel_i = sel;
    s_wb_we_i  = we;
    s_wb_dat_i = dat;
    s_wb_cyc_i = 1'b1;
    s_wb_stb_i = 1'b1;
    invalidate = inv;
    while (!got && lat < 200) begin
      @(negedge sys_clk);
      if (lat == 0) invalidate = 1'b0;
      lat++;
      if (s_wb_ack_o) begin
        got  = 1'b1;
        rdat = s_wb_dat_o;
      end
    end
    s_wb_cyc_i = 1'b0;
    s_wb_stb_i = 1'b0;
    s_wb_we_i  = 1'b0;
  endtask

  task automatic run_and_check(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                               input logic [31:0] dat, input logic inv);
    logic        cacheable, hit, got;
    logic [31:0] rdat, exp_dat;
    int          lat;
    txn_t        exp_q[$];
    cacheable = !we && (sel == 4'b1111);
    hit       = cacheable && mv && (mtag == adr[22:4]);
    if (cacheable && !hit) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{adr: {adr[31:4], 4'b0000} + 32'(4 * i), sel: 4'b1111, we: 1'b0,
                          dat: 32'h0});
      end
    end else if (!cacheable) begin
      exp_q.push_back('{adr: adr, sel: sel, we: we, dat: dat});
    end
    if (hit) exp_dat = mline[adr[3:2]];
    else if (cacheable) exp_dat = {adr[31:2], 2'b00};
    else exp_dat = adr;

    wb_req(adr, sel, we, dat, inv, rdat, lat, got);
    check_eq("ack_seen", 32'(got), 32'd1);
    if (!we) check_eq("read_data", rdat, exp_dat);
    if (hit) check_eq("hit_latency", 32'(lat), 32'd1);
    check_eq("master_txn_count", 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check_eq("master_adr", mon_q[i].adr, exp_q[i].adr);
      check_eq("master_sel", 32'(mon_q[i].sel), 32'(exp_q[i].sel));
      check_eq("master_we", 32'(mon_q[i].we), 32'(exp_q[i].we));
      if (exp_q[i].we) check_eq("master_wdat", mon_q[i].dat, exp_q[i].dat);
    end
    @(negedge sys_clk);
    check_eq("ack_single", 32'(s_wb_ack_o), 32'd0);

    if (cacheable && !hit) begin
      mv   = 1'b1;
      mtag = adr[22:4];
      for (int i = 0; i < 4; i++) mline[i] = {adr[31:4], 4'b0000} + 32'(4 * i);
    end
    if (!cacheable && we && (mtag == adr[22:4])) mv = 1'b0;
    if (inv) mv = 1'b0;
  endtask

  initial begin
    logic saw_ack;
    int   n;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we, inv;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check_eq("rst_s_ack", 32'(s_wb_ack_o), 32'd0);
    check_eq("rst_m_cyc", 32'(m_wb_cyc_o), 32'd0);
    check_eq("rst_m_stb", 32'(m_wb_stb_o), 32'd0);
    check_eq("rst_m_we", 32'(m_wb_we_o), 32'd0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Cold miss, hit, matching write, refill, pass-through read
    run_and_check(32'h100, 4'hF, 1'b0, 32'h0, 1'b0);
    run_and_check(32'h108, 4'hF, 1'b0, 32'h0, 1'b0);
    run_and_check(32'h104, 4'h3, 1'b1, 32'hDEAD_BEEF, 1'b0);
    run_and_check(32'h108, 4'hF, 1'b0, 32'h0, 1'b0);
    run_and_check(32'h200, 4'hC, 1'b0, 32'h0, 1'b0);
    run_and_check(32'h10C, 4'hF, 1'b0, 32'h0, 1'b0);

    // Invalidate while word 2 of the line is being fetched
    fork
      run_and_check(32'h300, 4'hF, 1'b0, 32'h0, 1'b0);
      begin
        n = 0;
        @(negedge sys_clk);
        while (mon_q.size() < 2 && n < 100) begin
          @(negedge sys_clk);
          n++;
        end
        check_eq("inv_wait", 32'(mon_q.size()), 32'd2);
        invalidate = 1'b1;
        @(negedge sys_clk);
        invalidate = 1'b0;
      end
    join
    mv = 1'b0;
    run_and_check(32'h304, 4'hF, 1'b0, 32'h0, 1'b0);

    // Slave abandons a fill: line still completes, no ack
    mon_q.delete();
    @(negedge sys_clk);
    s_wb_adr_i = 32'h400;
    s_wb_sel_i = 4'hF;
    s_wb_cyc_i = 1'b1;
    s_wb_stb_i = 1'b1;
    repeat (2) @(negedge sys_clk);
    s_wb_cyc_i = 1'b0;
    s_wb_stb_i = 1'b0;
    saw_ack = 1'b0;
    n = 0;
    while (!(mon_q.size() == 4 && !m_wb_cyc_o) && n < 100) begin
      @(negedge sys_clk);
      if (s_wb_ack_o) saw_ack = 1'b1;
      n++;
    end
    repeat (2) begin
      @(negedge sys_clk);
      if (s_wb_ack_o) saw_ack = 1'b1;
    end
    check_eq("abort_no_ack", 32'(saw_ack), 32'd0);
    check_eq("abort_fill_count", 32'(mon_q.size()), 32'd4);
    mv   = 1'b1;
    mtag = 19'h40;
    for (int i = 0; i < 4; i++) mline[i] = 32'h400 + 32'(4 * i);
    run_and_check(32'h404, 4'hF, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a fill
    mon_q.delete();
    @(negedge sys_clk);
    s_wb_adr_i = 32'h500;
    s_wb_sel_i = 4'hF;
    s_wb_cyc_i = 1'b1;
    s_wb_stb_i = 1'b1;
    n = 0;
    while (mon_q.size() < 1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("pre_rst_cyc", 32'(m_wb_cyc_o), 32'd1);
    sys_rst = 1'b1;
    #1;
    check_eq("async_rst_cyc", 32'(m_wb_cyc_o), 32'd0);
    check_eq("async_rst_stb", 32'(m_wb_stb_o), 32'd0);
    s_wb_cyc_i = 1'b0;
    s_wb_stb_i = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    mv = 1'b0;
    @(negedge sys_clk);
    run_and_check(32'h100, 4'hF, 1'b0, 32'h0, 1'b0);

    // Randomized traffic over a few lines, with aliasing above the decoded address bits
    for (int k = 0; k < 80; k++) begin
      adr = 32'h1000 + 32'($urandom_range(0, 5) << 4) + 32'($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) adr[31:23] = 9'($urandom);
      if ($urandom_range(0, 9) < 8) sel = 4'hF;
      else sel = 4'($urandom_range(1, 15));
      we  = ($urandom_range(0, 99) < 15);
      inv = ($urandom_range(0, 99) < 10);
      run_and_check(adr, sel, we, $urandom, inv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
